// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared types and widths for the ID/EX pipeline register and its halt-drain FSM.
// The datapath widths match the 16-bit, 8-register five-stage core.
package id_ex_pipe_reg_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int OP_W   = 5;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } halt_state_e;

    // Controls travelling towards MEM/WB; these are cleared by bubbles and flushes.
    typedef struct packed {
        logic reg_write;
        logic dmem_write;
        logic dmem_en;
        logic halt;
    } ctrl_t;

    // Selects and data; these hold through bubbles and flushes.
    typedef struct packed {
        logic [REG_W-1:0]  rr1;
        logic [REG_W-1:0]  rr2;
        logic [REG_W-1:0]  wsel;
        logic [OP_W-1:0]   alu_op;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pcp2;
    } ex_data_t;

endpackage

// File: rtl/id_ex_pipe_reg_halt_drain_fsm.sv
// Halt-drain state machine: after a HALT reaches EX, this FSM holds fetch for
// DRAIN_CYC non-frozen cycles and then reports that the core is quiescent.
module halt_drain_fsm
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DRAIN_CYC = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic freeze,
    input  logic flush,
    input  logic halt_load,
    output logic fetch_hold,
    output logic halted
);

    localparam int DCW = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DCW-1:0] DRAIN_INIT = DCW'(DRAIN_CYC);
    localparam logic [DCW-1:0] DCNT_ONE   = DCW'(1);

    halt_state_e      state_q, state_d;
    logic [DCW-1:0]   dcnt_q, dcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (!freeze) begin
            unique case (state_q)
                ST_RUN: begin
                    if (halt_load) begin
                        state_d = ST_DRAIN;
                        dcnt_d  = DRAIN_INIT;
                    end
                end
                ST_DRAIN: begin
                    // A taken branch in EX means the halt was on the wrong path.
                    if (flush) begin
                        state_d = ST_RUN;
                        dcnt_d  = '0;
                    end else if (dcnt_q <= DCNT_ONE) begin
                        state_d = ST_HALTED;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q - DCNT_ONE;
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        fetch_hold = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_DRAIN:  fetch_hold = 1'b1;
            ST_HALTED: begin
                fetch_hold = 1'b1;
                halted     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with bubble/flush/freeze handling,
// a saturating load-use bubble counter and the halt-drain controller.
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              bubble,
    input  logic              dec_valid,
    input  logic [REG_W-1:0]  dec_ReadReg1,
    input  logic [REG_W-1:0]  dec_ReadReg2,
    input  logic [REG_W-1:0]  dec_WriteRegSel,
    input  logic              dec_RegWrite,
    input  logic              dec_DMemWrite,
    input  logic              dec_DMemEn,
    input  logic              dec_Halt,
    input  logic [OP_W-1:0]   dec_AluOp,
    input  logic [DATA_W-1:0] dec_ReadData1,
    input  logic [DATA_W-1:0] dec_ReadData2,
    input  logic [DATA_W-1:0] dec_Imm,
    input  logic [DATA_W-1:0] dec_PCp2,
    output logic              exe_valid,
    output logic [REG_W-1:0]  exe_ReadReg1,
    output logic [REG_W-1:0]  exe_ReadReg2,
    output logic [REG_W-1:0]  exe_writeRegSel,
    output logic              exe_RegWrite,
    output logic              exe_DMemWrite,
    output logic              exe_DMemEn,
    output logic              exe_Halt,
    output logic [OP_W-1:0]   exe_AluOp,
    output logic [DATA_W-1:0] exe_ReadData1,
    output logic [DATA_W-1:0] exe_ReadData2,
    output logic [DATA_W-1:0] exe_Imm,
    output logic [DATA_W-1:0] exe_PCp2,
    output logic              fetch_hold,
    output logic              halted,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             valid_q, valid_d;
    ctrl_t            ctrl_q, ctrl_d, dec_ctrl;
    ex_data_t         data_q, data_d, dec_data;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             load;
    logic             halt_load;

    always_comb begin
        dec_ctrl = '{reg_write:  dec_RegWrite,
                     dmem_write: dec_DMemWrite,
                     dmem_en:    dec_DMemEn,
                     halt:       dec_Halt};
        dec_data = '{rr1:    dec_ReadReg1,
                     rr2:    dec_ReadReg2,
                     wsel:   dec_WriteRegSel,
                     alu_op: dec_AluOp,
                     rd1:    dec_ReadData1,
                     rd2:    dec_ReadData2,
                     imm:    dec_Imm,
                     pcp2:   dec_PCp2};
        load      = !freeze && !flush && !bubble;
        halt_load = load && dec_valid && dec_Halt;
    end

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        bcnt_d  = bcnt_q;
        if (freeze) begin
            // Memory busy: everything holds, including the bubble counter.
        end else if (flush || bubble) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (!flush && (bcnt_q != '1))
                bcnt_d = bcnt_q + CNT_ONE;
        end else begin
            // Controls are gated by valid so forwarding never sees a phantom write.
            valid_d = dec_valid;
            ctrl_d  = dec_valid ? dec_ctrl : '0;
            data_d  = dec_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            bcnt_q  <= bcnt_d;
        end
    end

    halt_drain_fsm #(
        .DRAIN_CYC (DRAIN_CYC)
    ) u_halt_fsm (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush      (flush),
        .halt_load  (halt_load),
        .fetch_hold (fetch_hold),
        .halted     (halted)
    );

    assign exe_valid       = valid_q;
    assign exe_RegWrite    = ctrl_q.reg_write;
    assign exe_DMemWrite   = ctrl_q.dmem_write;
    assign exe_DMemEn      = ctrl_q.dmem_en;
    assign exe_Halt        = ctrl_q.halt;
    assign exe_ReadReg1    = data_q.rr1;
    assign exe_ReadReg2    = data_q.rr2;
    assign exe_writeRegSel = data_q.wsel;
    assign exe_AluOp       = data_q.alu_op;
    assign exe_ReadData1   = data_q.rd1;
    assign exe_ReadData2   = data_q.rd2;
    assign exe_Imm         = data_q.imm;
    assign exe_PCp2        = data_q.pcp2;
    assign bubble_cnt      = bcnt_q;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register for the 16-bit, 8-register five-stage core.
- Produces the execute-stage register selects and memory/writeback controls consumed by the forwarding/hazard unit: exe_ReadReg1/2, exe_writeRegSel, and the control bits travelling to MEM.
- Applies load-use bubbles, branch flushes and global memory freezes.
- Owns the halt-drain state machine and a bubble performance counter.

Parameters:
- DATA_W, 16, datapath width (operands, immediate, PC+2)
- REG_W, 3, register select width
- OP_W, 5, ALU operation code width
- CNT_W, 16, bubble counter width
- DRAIN_CYC, 3, non-frozen cycles from halt entering EX until the core is quiescent

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- freeze  in  1  global hold (data memory busy); highest priority
- flush  in  1  branch/jump resolved taken in EX; kill the instruction entering EX
- bubble  in  1  load-use stall from the hazard unit; insert a NOP into EX
- dec_valid  in  1  decode holds a real instruction
- dec_ReadReg1, dec_ReadReg2, dec_WriteRegSel  in  REG_W each  decode register selects
- dec_RegWrite, dec_DMemWrite, dec_DMemEn, dec_Halt  in  1 each  decode controls
- dec_AluOp  in  OP_W  ALU operation
- dec_ReadData1, dec_ReadData2, dec_Imm, dec_PCp2  in  DATA_W each  operands, immediate, PC+2
- exe_valid  out  1  EX holds a real instruction
- exe_ReadReg1, exe_ReadReg2, exe_writeRegSel  out  REG_W each  registered selects
- exe_RegWrite, exe_DMemWrite, exe_DMemEn, exe_Halt  out  1 each  registered controls
- exe_AluOp  out  OP_W  registered ALU op
- exe_ReadData1, exe_ReadData2, exe_Imm, exe_PCp2  out  DATA_W each  registered data
- fetch_hold  out  1  stop PC update and fetch (halt draining or halted)
- halted  out  1  core quiescent after HALT
- bubble_cnt  out  CNT_W  number of inserted load-use bubbles

Behaviour:
- Reset (async, immediate): all outputs 0; FSM = RUN; drain counter 0; bubble_cnt 0.
- Register update priority each rising edge:
  1. freeze: every register holds; the FSM and counters do not advance.
  2. flush: exe_valid, exe_RegWrite, exe_DMemWrite, exe_DMemEn and exe_Halt go to 0. Selects, data and AluOp hold their previous values.
  3. bubble: same clearing as flush; bubble_cnt increments and saturates at all-ones.
  4. Otherwise: load all fields from dec_*.
- Load with dec_valid=0: exe_valid and all four control bits load 0. Selects and data load normally.
- Latency: one cycle from decode to EX outputs.
- Controls are never 1 while exe_valid=0. The hazard unit therefore never forwards from a bubble.
- flush and bubble asserted in the same cycle: flush wins and bubble_cnt does not increment.
- FSM states RUN, DRAIN, HALTED:
  - RUN: a load with dec_valid=1 and dec_Halt=1 moves to DRAIN with the counter set to DRAIN_CYC.
  - DRAIN: fetch_hold=1. The counter decrements on each non-frozen edge. At 0 the FSM moves to HALTED. A flush edge in DRAIN returns to RUN (wrong-path halt); fetch_hold deasserts the next cycle.
  - HALTED: fetch_hold=1 and halted=1. Left only by reset. Pipeline registers keep loading, but fetch_hold keeps decode supplying dec_valid=0.
- The halt instruction itself is still loaded into EX (exe_Halt=1) so downstream stages see it.
- Reset mid-drain returns to RUN with all outputs 0.
- The block is purely registers plus selects. It adds no combinational path from dec_* to exe_*.

Decomposition:
- Shared package holds:
  - widths DATA_W, REG_W, OP_W
  - FSM state encoding: RUN=2'b00, DRAIN=2'b01, HALTED=2'b10
  - the control-bundle struct: RegWrite, DMemWrite, DMemEn, Halt
- One natural sub-module, halt_drain_fsm, containing the FSM, drain counter, fetch_hold and halted.
- The register bank and bubble counter stay in the top module.

Test Plan:
- Reset during load: assert rst mid-cycle with dec_RegWrite=1, dec_WriteRegSel=3'd5 -> all outputs are 0 immediately, without a clock edge.
- Normal load: load dec_ReadReg1=3'd2, dec_ReadReg2=3'd4, dec_ReadData1=16'h1234, dec_valid=1 -> next cycle exe_ReadReg1=2, exe_ReadReg2=4, exe_ReadData1=16'h1234, exe_valid=1.
- Load-use bubble: bubble=1 for 1 cycle -> exe_valid=0, exe_RegWrite=0, exe_DMemEn=0, bubble_cnt goes 0->1. Repeat bubble 3 more times -> bubble_cnt=4.
- Freeze with flush and bubble: freeze=1 for 2 cycles with flush=1 and bubble=1 -> all exe_* unchanged and bubble_cnt unchanged. Release freeze with flush=1 -> bubble_cnt stays unchanged.
- Halt drain: load dec_Halt=1, dec_valid=1 -> exe_Halt=1 and fetch_hold=1 next cycle. Freeze for 1 cycle during drain -> halted rises after 3 non-frozen cycles (4 cycles total) and stays high.
- Wrong-path halt: load a halt, then flush the following cycle -> FSM returns to RUN, fetch_hold=0, halted never asserts, exe_Halt=0.
